// File: rtl/sd_pio_in_edge.sv
// sd_pio_in_edge
// Avalon-MM input port with synchroniser, optional per-bit debounce filter,
// sticky edge capture (write-1-to-clear) and a masked level interrupt.
//
// Parameters:
//   WIDTH     number of input bits (1..32); unused readdata bits read as 0
//   EDGE_TYPE 0 = rising, 1 = falling, 2 = any edge captured
//   DEBOUNCE  stable cycles required before a level change is accepted
//             (0 bypasses the filter)
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   address    word register select: 0 DATA, 1 reserved, 2 IRQMASK, 3 EDGECAP
//   chipselect slave select, qualifies writes only
//   write_n    active-low write strobe
//   writedata  write data
//   in_port    asynchronous external inputs
//   readdata   registered read data (1-cycle latency, no side effects)
//   irq        level interrupt, high while any masked EDGECAP bit is set
module sd_pio_in_edge #(
  parameter int WIDTH     = 8,
  parameter int EDGE_TYPE = 0,
  parameter int DEBOUNCE  = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int CNT_W = (DEBOUNCE > 0) ? $clog2(DEBOUNCE + 1) : 1;
  // The counter toggles stable on the cycle it would reach DEBOUNCE, so the
  // level change lands exactly DEBOUNCE cycles after s2 first differs.
  localparam logic [CNT_W-1:0] CNT_LAST = (DEBOUNCE > 0) ? CNT_W'(DEBOUNCE - 1) : '0;

  logic [WIDTH-1:0]            s1_q, s1_d;
  logic [WIDTH-1:0]            s2_q, s2_d;
  logic [WIDTH-1:0]            stable_q, stable_d;
  logic [WIDTH-1:0]            prev_q, prev_d;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]            edgecap_q, edgecap_d;
  logic [WIDTH-1:0]            irqmask_q, irqmask_d;
  logic [31:0]                 readdata_q, readdata_d;

  logic [WIDTH-1:0] edge_det;
  logic             wr_en;

  // Only the low WIDTH bits of writedata are stored; the rest are ignored.
  logic unused_wdata;
  assign unused_wdata = ^writedata;

  assign wr_en = chipselect & ~write_n;

  // Synchroniser and debounce filter
  always_comb begin
    s1_d     = in_port;
    s2_d     = s1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (DEBOUNCE == 0) begin
      stable_d = s2_q;
      cnt_d    = '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (s2_q[i] == stable_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = ~stable_q[i];
          cnt_d[i]    = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Edge detection, capture and mask
  always_comb begin
    prev_d = stable_q;
    case (EDGE_TYPE)
      0:       edge_det = stable_q & ~prev_q;
      1:       edge_det = ~stable_q & prev_q;
      default: edge_det = stable_q ^ prev_q;
    endcase

    edgecap_d = edgecap_q;
    if (wr_en && address == 2'd3) begin
      edgecap_d = edgecap_d & ~writedata[WIDTH-1:0];
    end
    // Applied after the clear so a coincident edge wins.
    edgecap_d = edgecap_d | edge_det;

    irqmask_d = irqmask_q;
    if (wr_en && address == 2'd2) begin
      irqmask_d = writedata[WIDTH-1:0];
    end
  end

  // Read mux, registered every cycle regardless of chipselect
  always_comb begin
    readdata_d = '0;
    case (address)
      2'd0:    readdata_d[WIDTH-1:0] = stable_q;
      2'd2:    readdata_d[WIDTH-1:0] = irqmask_q;
      2'd3:    readdata_d[WIDTH-1:0] = edgecap_q;
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q       <= '0;
      s2_q       <= '0;
      stable_q   <= '0;
      prev_q     <= '0;
      cnt_q      <= '0;
      edgecap_q  <= '0;
      irqmask_q  <= '0;
      readdata_q <= '0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      stable_q   <= stable_d;
      prev_q     <= prev_d;
      cnt_q      <= cnt_d;
      edgecap_q  <= edgecap_d;
      irqmask_q  <= irqmask_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  // Decoded purely from flops so the interrupt line cannot glitch.
  assign irq      = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_sd_pio_in_edge.sv
module tb_sd_pio_in_edge;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_r, in_f, in_a, in_d;
  logic [31:0] rd_r, rd_f, rd_a, rd_d;
  logic        irq_r, irq_f, irq_a, irq_d;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  // rising, no debounce
  sd_pio_in_edge #(.WIDTH(8), .EDGE_TYPE(0), .DEBOUNCE(0)) dut_r (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_r),
    .readdata(rd_r), .irq(irq_r));
  // falling, no debounce
  sd_pio_in_edge #(.WIDTH(8), .EDGE_TYPE(1), .DEBOUNCE(0)) dut_f (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_f),
    .readdata(rd_f), .irq(irq_f));
  // any edge, no debounce
  sd_pio_in_edge #(.WIDTH(8), .EDGE_TYPE(2), .DEBOUNCE(0)) dut_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_a),
    .readdata(rd_a), .irq(irq_a));
  // rising, debounce 4
  sd_pio_in_edge #(.WIDTH(8), .EDGE_TYPE(0), .DEBOUNCE(4)) dut_d (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_d),
    .readdata(rd_d), .irq(irq_d));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic bus_write(input logic cs, input logic [1:0] a, input logic [31:0] d);
    chipselect = cs;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd0;
    writedata  = '0;
  endtask

  // readdata after this returns the register value as of the previous edge
  task automatic bus_read(input logic [1:0] a);
    address = a;
    tick();
  endtask

  task automatic apply_reset();
    in_r = '0; in_f = '0; in_a = '0; in_d = '0;
    address = 2'd0;
    #3 reset_n = 1'b0;
    ticks(2);
    reset_n = 1'b1;
    ticks(6);
  endtask

  task automatic test_reset();
    apply_reset();
    in_r = 8'hFF;
    bus_write(1'b1, 2'd2, 32'hFF);
    ticks(5);
    tests++;
    if (irq_r !== 1'b1) begin fails++; $display("FAIL reset_pre_irq got %b exp 1", irq_r); end
    tests++;
    if (rd_r !== 32'hFF) begin fails++; $display("FAIL reset_pre_data got %h exp %h", rd_r, 32'hFF); end
    #3 reset_n = 1'b0;
    #1;
    tests++;
    if (rd_r !== 32'h0) begin fails++; $display("FAIL reset_async_rd got %h exp %h", rd_r, 32'h0); end
    tests++;
    if (irq_r !== 1'b0) begin fails++; $display("FAIL reset_async_irq got %b exp 0", irq_r); end
    tick();
    reset_n = 1'b1;
    ticks(3);
    tests++;
    if (rd_r !== 32'h0) begin fails++; $display("FAIL reset_data_early got %h exp %h", rd_r, 32'h0); end
    tick();
    tests++;
    if (rd_r !== 32'hFF) begin fails++; $display("FAIL reset_data_4cyc got %h exp %h", rd_r, 32'hFF); end
    tick();
    tests++;
    if (irq_r !== 1'b0) begin fails++; $display("FAIL reset_irq_after got %b exp 0", irq_r); end
    bus_read(2'd2);
    tests++;
    if (rd_r !== 32'h0) begin fails++; $display("FAIL reset_irqmask got %h exp %h", rd_r, 32'h0); end
    bus_read(2'd3);
    tests++;
    if (rd_r !== 32'hFF) begin fails++; $display("FAIL reset_release_edge got %h exp %h", rd_r, 32'hFF); end
  endtask

  task automatic test_rising();
    apply_reset();
    bus_write(1'b1, 2'd2, 32'h05);
    in_r = 8'h01;
    ticks(3);
    tests++;
    if (irq_r !== 1'b0) begin fails++; $display("FAIL rise_irq_early got %b exp 0", irq_r); end
    tick();
    tests++;
    if (irq_r !== 1'b1) begin fails++; $display("FAIL rise_irq_edge4 got %b exp 1", irq_r); end
    bus_read(2'd3);
    tests++;
    if (rd_r !== 32'h01) begin fails++; $display("FAIL rise_edgecap got %h exp %h", rd_r, 32'h01); end
    bus_write(1'b1, 2'd3, 32'h01);
    tests++;
    if (irq_r !== 1'b0) begin fails++; $display("FAIL rise_w1c_irq got %b exp 0", irq_r); end
    bus_read(2'd3);
    tests++;
    if (rd_r !== 32'h0) begin fails++; $display("FAIL rise_w1c_cap got %h exp %h", rd_r, 32'h0); end
  endtask

  task automatic test_falling();
    apply_reset();
    in_f = 8'hFF;
    ticks(6);
    bus_read(2'd3);
    tests++;
    if (rd_f !== 32'h0) begin fails++; $display("FAIL fall_no_rise got %h exp %h", rd_f, 32'h0); end
    in_f = 8'hF7;
    ticks(4);
    tests++;
    if (irq_f !== 1'b0) begin fails++; $display("FAIL fall_masked_irq got %b exp 0", irq_f); end
    bus_read(2'd3);
    tests++;
    if (rd_f !== 32'h08) begin fails++; $display("FAIL fall_edgecap got %h exp %h", rd_f, 32'h08); end
    bus_write(1'b1, 2'd2, 32'h08);
    tests++;
    if (irq_f !== 1'b1) begin fails++; $display("FAIL fall_unmask_irq got %b exp 1", irq_f); end
  endtask

  task automatic test_debounce();
    apply_reset();
    in_d = 8'h01;
    ticks(3);
    in_d = 8'h00;
    ticks(8);
    tests++;
    if (rd_d !== 32'h0) begin fails++; $display("FAIL deb_glitch_data got %h exp %h", rd_d, 32'h0); end
    bus_read(2'd3);
    tests++;
    if (rd_d !== 32'h0) begin fails++; $display("FAIL deb_glitch_cap got %h exp %h", rd_d, 32'h0); end
    address = 2'd0;
    in_d = 8'h01;
    ticks(6);
    tests++;
    if (rd_d !== 32'h0) begin fails++; $display("FAIL deb_early got %h exp %h", rd_d, 32'h0); end
    in_d = 8'h00;
    tick();
    tests++;
    if (rd_d !== 32'h01) begin fails++; $display("FAIL deb_on_time got %h exp %h", rd_d, 32'h01); end
    ticks(8);
    bus_read(2'd3);
    tests++;
    if (rd_d !== 32'h01) begin fails++; $display("FAIL deb_edgecap got %h exp %h", rd_d, 32'h01); end
  endtask

  task automatic test_collision();
    apply_reset();
    in_a = 8'h04;
    ticks(3);
    bus_write(1'b1, 2'd3, 32'h04);
    bus_read(2'd3);
    tests++;
    if (rd_a !== 32'h04) begin fails++; $display("FAIL coll_set_wins got %h exp %h", rd_a, 32'h04); end
    bus_write(1'b1, 2'd3, 32'h04);
    bus_read(2'd3);
    tests++;
    if (rd_a !== 32'h0) begin fails++; $display("FAIL coll_clear got %h exp %h", rd_a, 32'h0); end
    in_a = 8'h00;
    ticks(4);
    bus_read(2'd3);
    tests++;
    if (rd_a !== 32'h04) begin fails++; $display("FAIL coll_any_fall got %h exp %h", rd_a, 32'h04); end
  endtask

  task automatic test_decode();
    apply_reset();
    in_r = 8'hFF;
    bus_write(1'b1, 2'd2, 32'hFF);
    ticks(5);
    bus_read(2'd1);
    tests++;
    if (rd_r !== 32'h0) begin fails++; $display("FAIL dec_reserved got %h exp %h", rd_r, 32'h0); end
    bus_read(2'd0);
    tests++;
    if (rd_r !== 32'hFF) begin fails++; $display("FAIL dec_data got %h exp %h", rd_r, 32'hFF); end
    bus_write(1'b0, 2'd2, 32'h00);
    bus_write(1'b0, 2'd3, 32'hFF);
    bus_write(1'b1, 2'd0, 32'hFF);
    bus_write(1'b1, 2'd0, 32'h00);
    bus_write(1'b1, 2'd1, 32'hFF);
    bus_write(1'b1, 2'd1, 32'h00);
    bus_read(2'd2);
    tests++;
    if (rd_r !== 32'hFF) begin fails++; $display("FAIL dec_mask_kept got %h exp %h", rd_r, 32'hFF); end
    bus_read(2'd3);
    tests++;
    if (rd_r !== 32'hFF) begin fails++; $display("FAIL dec_cap_kept got %h exp %h", rd_r, 32'hFF); end
    tests++;
    if (irq_r !== 1'b1) begin fails++; $display("FAIL dec_irq_kept got %b exp 1", irq_r); end
    bus_write(1'b1, 2'd2, 32'h00);
    tests++;
    if (irq_r !== 1'b0) begin fails++; $display("FAIL dec_mask_off_irq got %b exp 0", irq_r); end
    bus_write(1'b1, 2'd2, 32'hFFFF_FFFF);
    bus_read(2'd2);
    tests++;
    if (rd_r !== 32'h0000_00FF) begin fails++; $display("FAIL dec_mask_width got %h exp %h", rd_r, 32'h0000_00FF); end
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_r = '0; in_f = '0; in_a = '0; in_d = '0;
    ticks(2);
    reset_n = 1'b1;
    ticks(2);
    test_reset();
    test_rising();
    test_falling();
    test_debounce();
    test_collision();
    test_decode();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
